instruction_fetch: RTL and testbench

Fetch stage of the RISC-V core, directly upstream of the instruction controller/decoder. It owns the program counter and issues word reads to instruction memory over a request/grant port that accepts in-order, variable-latency responses. Returned words are buffered with their PCs in a small queue and presented to decode as `instructionCode` with a valid/ready handshake. A redirect input (branch/jump/exception) flushes all in-flight fetches.

---
 rtl/instruction_fetch_pkg.sv | 34 +++
 rtl/instruction_fetch_if.sv | 31 +++
 rtl/instruction_fetch_queue.sv | 54 +++++
 rtl/instruction_fetch.sv | 90 +++++++++
 tb/tb_instruction_fetch.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared RISC-V front-end definitions: XLEN, reset PC, NOP encoding, opcodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instruction_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

  // Major opcodes used by the instruction controller/decoder.
  localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b000_1111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC    = 7'b001_0111;
  localparam logic [6:0] OPC_STORE    = 7'b010_0011;
  localparam logic [6:0] OPC_OP       = 7'b011_0011;
  localparam logic [6:0] OPC_LUI      = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
  localparam logic [6:0] OPC_JALR     = 7'b110_0111;
  localparam logic [6:0] OPC_JAL      = 7'b110_1111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b111_0011;

  // One buffered fetch result: the word and the PC it was read from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetchEntry_t;

  function automatic logic [XLEN-1:0] wordAlign(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: imem request/grant/response, decode handshake, redirect.
// Latency: n/a (wires only).
// Backpressure: imemGnt stalls requests, decodeReady stalls delivery.
// master = fetch stage view, slave = memory/decode/redirect side.
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic            imemReq;
  logic [XLEN-1:0] imemAddr;
  logic            imemGnt;
  logic            imemRvalid;
  logic [XLEN-1:0] imemRdata;

  logic            instValid;
  logic            decodeReady;
  logic [XLEN-1:0] instructionCode;
  logic [XLEN-1:0] pcOut;

  logic            redirectValid;
  logic [XLEN-1:0] redirectPc;

  modport master (
    output imemReq, imemAddr, instValid, instructionCode, pcOut,
    input  imemGnt, imemRvalid, imemRdata, decodeReady, redirectValid, redirectPc
  );

  modport slave (
    input  imemReq, imemAddr, instValid, instructionCode, pcOut,
    output imemGnt, imemRvalid, imemRdata, decodeReady, redirectValid, redirectPc
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Synchronous FIFO with flush and occupancy count, async active-high reset.
// Latency: a push is visible at popData the cycle after it is written.
// Backpressure: pushes while full are dropped unless a pop frees the slot.
// Ports: push/pushData in, pop/popData out, flush, full/empty/count status.
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       pushData,
  input  logic                   pop,
  output logic [WIDTH-1:0]       popData,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];

  // Storage carries no reset; empty/count qualify the head.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// RISC-V fetch stage: owns the PC, issues credit-limited imem reads, queues {pc, word} for decode.
// Latency: memory latency + 1 cycle from grant to instValid; redirect clears instValid next cycle.
// Backpressure: requests issue only while outstanding + queued fits QUEUE_DEPTH, so responses never stall.
// Ports: clk, rst (async active-high); bus = imem req/gnt/rvalid/rdata, decode valid/ready, redirect.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int              QUEUE_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus
);
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic [XLEN-1:0]  fetchPc;      // next address to issue
  logic [XLEN-1:0]  respPc;       // PC of the next response that will be kept
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] dropCount;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W:0]   creditUse;

  logic             qEmpty;
  logic             qFull;
  fetchEntry_t      headEntry;
  fetchEntry_t      pushEntry;

  logic             pop;
  logic             issue;
  logic             respValid;
  logic             respKeep;
  logic             push;

  assign pop       = bus.instValid && bus.decodeReady;
  // A response with nothing in flight is a protocol error (or a pre-reset straggler): ignore it.
  assign respValid = bus.imemRvalid && (outstanding != '0);
  assign respKeep  = respValid && (dropCount == '0);
  assign push      = respKeep && !bus.redirectValid && (!qFull || pop);

  assign creditUse = (CNT_W+1)'(outstanding) + (CNT_W+1)'(occupancy) - (CNT_W+1)'(pop);

  assign bus.imemReq  = !rst && !bus.redirectValid && (creditUse < (CNT_W+1)'(QUEUE_DEPTH));
  assign bus.imemAddr = fetchPc;
  assign issue        = bus.imemReq && bus.imemGnt;

  // Responses return in issue order and kept ones are sequential since the last
  // redirect, so a single running PC labels them; dropped ones never advance it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetchPc     <= RESET_PC;
      respPc      <= RESET_PC;
      outstanding <= '0;
      dropCount   <= '0;
    end else if (bus.redirectValid) begin
      fetchPc     <= wordAlign(bus.redirectPc);
      respPc      <= wordAlign(bus.redirectPc);
      outstanding <= outstanding - CNT_W'(respValid);
      // Everything still in flight after this cycle belongs to the old path.
      dropCount   <= outstanding - CNT_W'(respValid);
    end else begin
      if (issue) fetchPc <= fetchPc + 32'd4;
      outstanding <= outstanding + CNT_W'(issue) - CNT_W'(respValid);
      if (respValid && (dropCount != '0)) dropCount <= dropCount - CNT_W'(1);
      if (respKeep) respPc <= respPc + 32'd4;
    end
  end

  assign pushEntry = '{pc: respPc, instr: bus.imemRdata};

  fetch_queue #(
    .WIDTH($bits(fetchEntry_t)),
    .DEPTH(QUEUE_DEPTH)
  ) queue (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pushData (pushEntry),
    .pop      (pop),
    .popData  (headEntry),
    .flush    (bus.redirectValid),
    .full     (qFull),
    .empty    (qEmpty),
    .count    (occupancy)
  );

  assign bus.instValid       = !qEmpty;
  assign bus.instructionCode = qEmpty ? NOP_INSTR : headEntry.instr;
  assign bus.pcOut           = qEmpty ? '0 : headEntry.pc;
endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk;
  logic rst;

  instruction_fetch_if bus();

  instruction_fetch #(
    .RESET_PC    (RST_PC),
    .QUEUE_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];     // memory model: granted reads awaiting response
  logic [31:0] expQ[$];     // scoreboard: PCs decode must receive, in order
  logic [31:0] expPc;
  int          checks;
  int          errors;
  int          cyc;
  int          popCount;
  int          gntMode;     // 0 always grant, 1 random, 2 never
  int          latMin;
  int          latMax;
  logic        rstDrive;
  logic        lastWasTop;
  logic        wrapSeen;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    chk({tag, "_imemReq"}, 32'(bus.imemReq), 32'd0);
    chk({tag, "_imemAddr"}, bus.imemAddr, RST_PC);
    chk({tag, "_instValid"}, 32'(bus.instValid), 32'd0);
    chk({tag, "_instr"}, bus.instructionCode, NOP_INSTR);
    chk({tag, "_pcOut"}, bus.pcOut, 32'd0);
  endtask

  // One clock cycle: drive inputs at negedge, sample outputs 1ns later,
  // then update scoreboard/memory model for what the next posedge will do.
  task automatic tick(input logic rdy, input logic redir, input logic [31:0] rpc);
    logic [31:0] e;
    int          l;
    @(negedge clk);
    rst = rstDrive;
    if (!rstDrive && pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imemRvalid = 1'b1;
      bus.imemRdata  = memWord(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      bus.imemRvalid = 1'b0;
      bus.imemRdata  = $urandom;
    end
    case (gntMode)
      0:       bus.imemGnt = 1'b1;
      1:       bus.imemGnt = 1'($urandom_range(0, 1));
      default: bus.imemGnt = 1'b0;
    endcase
    bus.decodeReady   = rdy;
    bus.redirectValid = redir;
    bus.redirectPc    = rpc;
    #1;
    if (!rstDrive) begin
      if (bus.instValid && bus.decodeReady) begin
        popCount++;
        checks++;
        assert (expQ.size() != 0) else begin
          errors++;
          $error("FAIL pop_unexpected: observed pcOut %h expected no instruction", bus.pcOut);
        end
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          chk("pop_pc", bus.pcOut, e);
          chk("pop_instr", bus.instructionCode, memWord(e));
        end
      end
      if (bus.imemReq && bus.imemGnt) begin
        chk("grant_addr", bus.imemAddr, expPc);
        if (lastWasTop) begin
          chk("wrap_addr", bus.imemAddr, 32'h0000_0000);
          wrapSeen = 1'b1;
        end
        lastWasTop = (expPc == 32'hFFFF_FFFC);
        l = $urandom_range(latMax, latMin);
        pend.push_back('{addr: bus.imemAddr, due: cyc + l});
        expQ.push_back(expPc);
        expPc = expPc + 32'd4;
      end
      if (redir) begin
        expQ.delete();
        expPc = {rpc[31:2], 2'b00};
      end
    end else begin
      expQ.delete();
      expPc = RST_PC;
    end
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   startPops;
    int   bubbles;
    logic found;

    checks = 0; errors = 0; cyc = 0; popCount = 0;
    gntMode = 0; latMin = 1; latMax = 1;
    rstDrive = 1'b1; rst = 1'b1; lastWasTop = 1'b0; wrapSeen = 1'b0;
    expPc = RST_PC;
    bus.imemGnt = 1'b0; bus.imemRvalid = 1'b0; bus.imemRdata = '0;
    bus.decodeReady = 1'b0; bus.redirectValid = 1'b0; bus.redirectPc = '0;

    // Reset values
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    checkReset("reset");

    // Streaming, 1-cycle memory: first request at RESET_PC, pcOut from cycle 3, no bubbles
    rstDrive = 1'b0;
    tick(1'b1, 1'b0, '0);
    chk("first_req", 32'(bus.imemReq), 32'd1);
    chk("first_addr", bus.imemAddr, RST_PC);
    tick(1'b1, 1'b0, '0);
    chk("cycle2_instValid", 32'(bus.instValid), 32'd0);
    tick(1'b1, 1'b0, '0);
    chk("cycle3_instValid", 32'(bus.instValid), 32'd1);
    chk("cycle3_pcOut", bus.pcOut, RST_PC);
    bubbles = 0;
    for (int i = 0; i < 17; i++) begin
      tick(1'b1, 1'b0, '0);
      if (!bus.instValid) bubbles++;
    end
    chk("stream_bubbles", 32'(bubbles), 32'd0);

    // Decode stall: two entries held, requests stop, then released in order
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, '0);
    chk("stall_imemReq", 32'(bus.imemReq), 32'd0);
    chk("stall_instValid", 32'(bus.instValid), 32'd1);
    gntMode = 2;
    startPops = popCount;
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, '0);
    chk("stall_buffered", 32'(popCount - startPops), 32'd2);
    chk("stall_drained", 32'(bus.instValid), 32'd0);

    // Redirect with two fetches outstanding
    gntMode = 0; latMin = 3; latMax = 3;
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    chk("two_outstanding_req", 32'(bus.imemReq), 32'd0);
    tick(1'b1, 1'b1, 32'h0000_0102);
    tick(1'b1, 1'b0, '0);
    chk("redir_instValid", 32'(bus.instValid), 32'd0);
    chk("redir_addr", bus.imemAddr, 32'h0000_0100);
    chk("redir_req", 32'(bus.imemReq), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b1, 1'b0, '0);
      if (bus.instValid) begin
        found = 1'b1;
        chk("redir_first_pc", bus.pcOut, 32'h0000_0100);
      end
    end
    chk("redir_pop_seen", 32'(found), 32'd1);

    // Random grants, 1-4 cycle latency, random decode stalls, 1000 instructions
    gntMode = 1; latMin = 1; latMax = 4;
    startPops = popCount;
    for (int i = 0; i < 20000 && popCount < startPops + 1000; i++)
      tick($urandom_range(0, 3) != 0, 1'b0, '0);
    chk("random_delivered", 32'(popCount >= startPops + 1000), 32'd1);

    // PC wrap at the top of the address space
    gntMode = 0; latMin = 1; latMax = 1;
    tick(1'b1, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 12; i++) tick(1'b1, 1'b0, '0);
    chk("wrap_seen", 32'(wrapSeen), 32'd1);

    // Reset with one fetch in flight; its late response must be ignored
    gntMode = 2;
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0, '0);
    gntMode = 0; latMin = 3; latMax = 3;
    tick(1'b1, 1'b0, '0);
    gntMode = 2;
    rstDrive = 1'b1;
    tick(1'b1, 1'b0, '0);
    checkReset("midrst");
    tick(1'b1, 1'b0, '0);
    rstDrive = 1'b0;
    tick(1'b1, 1'b0, '0);
    chk("postrst_req", 32'(bus.imemReq), 32'd1);
    chk("postrst_addr", bus.imemAddr, RST_PC);
    gntMode = 0; latMin = 1; latMax = 1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b1, 1'b0, '0);
      if (bus.instValid) begin
        found = 1'b1;
        chk("postrst_first_pc", bus.pcOut, RST_PC);
        chk("postrst_first_instr", bus.instructionCode, memWord(RST_PC));
      end
    end
    chk("postrst_pop_seen", 32'(found), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
